// File: rtl/entrada_agua_ctrl_if.sv
// rtl/entrada_agua_ctrl_if.sv - signal bundle between sequencer, water-inlet controller, valves and level sensor
interface entrada_agua_ctrl_if #(
  parameter int N_VALVES = 2,
  parameter int LEVEL_W  = 8
);
  logic                start;
  logic                abort;
  logic                fault_clr;
  logic [LEVEL_W-1:0]  target_level;
  logic [N_VALVES-1:0] valve_mask;
  logic [LEVEL_W-1:0]  level_sensor;
  logic [N_VALVES-1:0] valve;
  logic                busy;
  logic                done;
  logic                fault;

  modport master (
    output start, abort, fault_clr, target_level, valve_mask, level_sensor,
    input  valve, busy, done, fault
  );

  modport slave (
    input  start, abort, fault_clr, target_level, valve_mask, level_sensor,
    output valve, busy, done, fault
  );
endinterface

// File: rtl/entrada_agua_ctrl.sv
// rtl/entrada_agua_ctrl.sv - N-valve water inlet controller with settle hysteresis, fill timeout and fault
module entrada_agua_ctrl #(
  parameter int N_VALVES       = 2,
  parameter int LEVEL_W        = 8,
  parameter int HYST           = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  entrada_agua_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SETTLE,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [LEVEL_W-1:0] HYST_L  = LEVEL_W'(HYST);
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   ST_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t              state, state_nx;
  logic [LEVEL_W-1:0]  tgt_q;
  logic [LEVEL_W-1:0]  refill_lvl;
  logic [N_VALVES-1:0] mask_q;
  logic [N_VALVES-1:0] valve_q, valve_nx;
  logic [CNT_W-1:0]    to_cnt, st_cnt;
  logic                busy_q, done_q, fault_q;
  logic                busy_nx, done_nx, fault_nx;
  logic                accept;
  logic                at_level;

  assign accept     = (state == S_IDLE) && bus.start && !bus.abort;
  assign at_level   = bus.level_sensor >= tgt_q;
  // Saturate at zero so a tiny target can never trigger a refill.
  assign refill_lvl = (tgt_q > HYST_L) ? (tgt_q - HYST_L) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tgt_q   <= '0;
      mask_q  <= '0;
      to_cnt  <= '0;
      st_cnt  <= '0;
      valve_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      valve_q <= valve_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      fault_q <= fault_nx;
      if (accept) begin
        tgt_q  <= bus.target_level;
        mask_q <= bus.valve_mask;
      end
      // Fill time accumulates across refills; only leaving the operation clears it.
      if (state == S_IDLE || state_nx == S_IDLE) begin
        to_cnt <= '0;
      end else if (state == S_FILL) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (state == S_SETTLE && state_nx == S_SETTLE) begin
        st_cnt <= st_cnt + 1'b1;
      end else begin
        st_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.abort && state != S_FAULT) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.valve_mask == '0) begin
              state_nx = S_FAULT;
            end else if (bus.level_sensor >= bus.target_level) begin
              state_nx = S_SETTLE;
            end else begin
              state_nx = S_FILL;
            end
          end
        end
        S_FILL: begin
          if (at_level) begin
            state_nx = S_SETTLE;
          end else if (to_cnt == TO_LAST) begin
            state_nx = S_FAULT;
          end
        end
        S_SETTLE: begin
          if (bus.level_sensor < refill_lvl) begin
            state_nx = S_FILL;
          end else if (st_cnt == ST_LAST) begin
            state_nx = S_DONE;
          end
        end
        S_DONE: begin
          if (!bus.start) begin
            state_nx = S_IDLE;
          end
        end
        S_FAULT: begin
          if (bus.fault_clr && !bus.start) begin
            state_nx = S_IDLE;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Outputs decode the next state so they register on the same edge as the state.
  always_comb begin
    valve_nx = '0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    fault_nx = 1'b0;
    case (state_nx)
      S_FILL: begin
        valve_nx = accept ? bus.valve_mask : mask_q;
        busy_nx  = 1'b1;
      end
      S_SETTLE: busy_nx  = 1'b1;
      S_DONE:   done_nx  = 1'b1;
      S_FAULT:  fault_nx = 1'b1;
      default: begin
        valve_nx = '0;
      end
    endcase
  end

  assign bus.valve = valve_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.fault = fault_q;
endmodule

// File: tb/tb_entrada_agua_ctrl.sv
// tb/tb_entrada_agua_ctrl.sv - self-checking bench for entrada_agua_ctrl
module tb_entrada_agua_ctrl;
  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  entrada_agua_ctrl_if #(.N_VALVES(2), .LEVEL_W(8)) bus_if ();

  entrada_agua_ctrl #(
    .N_VALVES(2), .LEVEL_W(8), .HYST(4), .SETTLE_CYCLES(16),
    .TIMEOUT_CYCLES(50), .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  // {valve[1:0], busy, done, fault}
  localparam logic [4:0] O_IDLE  = 5'b00_0_0_0;
  localparam logic [4:0] O_FILL1 = 5'b01_1_0_0;
  localparam logic [4:0] O_FILL3 = 5'b11_1_0_0;
  localparam logic [4:0] O_SET   = 5'b00_1_0_0;
  localparam logic [4:0] O_DONE  = 5'b00_0_1_0;
  localparam logic [4:0] O_FLT   = 5'b00_0_0_1;

  typedef struct {
    logic       start;
    logic       abort;
    logic       clr;
    logic [7:0] tgt;
    logic [1:0] mask;
    logic [7:0] lvl;
    logic [4:0] exp;
  } step_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  function automatic step_t mk(input logic s, input logic a, input logic c, input logic [7:0] t,
                               input logic [1:0] m, input logic [7:0] l, input logic [4:0] x);
    step_t r;
    r.start = s; r.abort = a; r.clr = c; r.tgt = t; r.mask = m; r.lvl = l; r.exp = x;
    return r;
  endfunction

  function automatic logic [4:0] obs();
    return {bus_if.valve, bus_if.busy, bus_if.done, bus_if.fault};
  endfunction

  task automatic apply(input step_t s);
    bus_if.start        = s.start;
    bus_if.abort        = s.abort;
    bus_if.fault_clr    = s.clr;
    bus_if.target_level = s.tgt;
    bus_if.valve_mask   = s.mask;
    bus_if.level_sensor = s.lvl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    apply(mk(0, 0, 0, 8'd0, 2'b00, 8'd0, O_IDLE));
    reset = 1'b1;
    exp_q.push_back(O_IDLE);
    tick();
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs(), e);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_fill();
    step_t st[$];
    logic [4:0] e;
    st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd0, O_FILL1));
    // Inputs after capture change deliberately; the captured values must hold.
    for (int k = 1; k <= 20; k++)
      st.push_back(mk(1, 0, 0, 8'd200, 2'b11, 8'(k * 5), (k < 20) ? O_FILL1 : O_SET));
    for (int k = 0; k < 15; k++) st.push_back(mk(1, 0, 0, 8'd200, 2'b11, 8'd100, O_SET));
    for (int k = 0; k < 4; k++)  st.push_back(mk(1, 0, 0, 8'd200, 2'b11, 8'd100, O_DONE));
    st.push_back(mk(0, 0, 0, 8'd200, 2'b11, 8'd100, O_IDLE));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL basic_fill step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_hysteresis();
    step_t st[$];
    logic [4:0] e;
    st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd50, O_FILL1));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd100, O_SET));
    for (int k = 0; k < 3; k++) st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd96, O_SET));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd95, O_FILL1));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd100, O_SET));
    st.push_back(mk(0, 1, 0, 8'd100, 2'b01, 8'd100, O_IDLE));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL hysteresis step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_timeout();
    step_t st[$];
    logic [4:0] e;
    for (int k = 0; k < 50; k++) st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd10, O_FILL1));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd10, O_FLT));
    st.push_back(mk(1, 0, 1, 8'd100, 2'b01, 8'd10, O_FLT));
    st.push_back(mk(1, 1, 0, 8'd100, 2'b01, 8'd10, O_FLT));
    st.push_back(mk(0, 0, 0, 8'd100, 2'b01, 8'd10, O_FLT));
    st.push_back(mk(0, 0, 1, 8'd100, 2'b01, 8'd10, O_IDLE));
    st.push_back(mk(0, 0, 0, 8'd100, 2'b01, 8'd10, O_IDLE));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL timeout step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t st[$];
    logic [4:0] e;
    for (int k = 0; k < 50; k++) st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd10, O_FILL1));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd100, O_SET));
    st.push_back(mk(0, 1, 0, 8'd100, 2'b01, 8'd100, O_IDLE));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL simultaneous step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_edges();
    step_t st[$];
    logic [4:0] e;
    st.push_back(mk(1, 0, 0, 8'd100, 2'b00, 8'd0, O_FLT));
    st.push_back(mk(0, 0, 1, 8'd100, 2'b00, 8'd0, O_IDLE));
    // Target at sensor level and below HYST: settles with no valve and no refill.
    st.push_back(mk(1, 0, 0, 8'd3, 2'b01, 8'd3, O_SET));
    for (int k = 0; k < 15; k++) st.push_back(mk(1, 0, 0, 8'd3, 2'b01, 8'd0, O_SET));
    st.push_back(mk(1, 0, 0, 8'd3, 2'b01, 8'd0, O_DONE));
    st.push_back(mk(0, 0, 0, 8'd3, 2'b01, 8'd0, O_IDLE));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b11, 8'd120, O_SET));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b11, 8'd120, O_SET));
    st.push_back(mk(0, 1, 0, 8'd100, 2'b11, 8'd120, O_IDLE));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL edges step %0d: got %b expected %b", i, obs(), e);
      end
    end
  endtask

  task automatic test_abort_reset();
    step_t st[$];
    logic [4:0] e;
    st.push_back(mk(1, 0, 0, 8'd100, 2'b11, 8'd0, O_FILL3));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b11, 8'd0, O_FILL3));
    st.push_back(mk(1, 1, 0, 8'd100, 2'b11, 8'd0, O_IDLE));
    st.push_back(mk(0, 0, 0, 8'd100, 2'b11, 8'd0, O_IDLE));
    st.push_back(mk(1, 0, 0, 8'd100, 2'b01, 8'd0, O_FILL1));
    st.push_back(mk(0, 0, 0, 8'd100, 2'b01, 8'd0, O_FILL1));
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(st[i].exp);
      tick();
      e = exp_q.pop_front();
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL abort step %0d: got %b expected %b", i, obs(), e);
      end
    end
    // Reset between edges must close the valves without a clock edge.
    #2;
    reset = 1'b1;
    exp_q.push_back(O_IDLE);
    #1;
    e = exp_q.pop_front();
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected %b", obs(), e);
    end
    #1;
    reset = 1'b0;
    exp_q.push_back(O_IDLE);
    tick();
    e = exp_q.pop_front();
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL after_reset: got %b expected %b", obs(), e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    test_reset();
    test_basic_fill();
    test_hysteresis();
    test_timeout();
    test_simultaneous();
    test_edges();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/entrada_agua_ctrl.md
Name: entrada_agua_ctrl

Overview:
- Parametrised successor to the single-valve water-inlet stage of the washing-machine controller.
- Drives N inlet valves (default: cold and hot) from a captured valve mask until the level sensor reaches a captured target level.
- Adds a settle/hysteresis check, a fill timeout with fault reporting, abort, and a done/start handshake.
- Sits between the wash-cycle sequencer (start/abort/target/mask) and the valve drivers and level sensor.

Parameters:
N_VALVES, 2, number of inlet valves; bit 0 is cold, bit 1 is hot.
LEVEL_W, 8, width of the level sensor and target level.
HYST, 4, allowed drop below target during SETTLE before refilling.
SETTLE_CYCLES, 16, consecutive cycles in SETTLE with valves closed before DONE.
TIMEOUT_CYCLES, 50000, maximum cumulative cycles spent in FILL per operation.
CNT_W, 16, width of the settle and timeout counters; must hold TIMEOUT_CYCLES.

Ports:
clock  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  level request from the sequencer; sampled in IDLE.
abort  in  1  cancels any operation; higher priority than start.
fault_clr  in  1  clears FAULT.
target_level  in  LEVEL_W  fill target; captured when start is accepted.
valve_mask  in  N_VALVES  valves to open; captured when start is accepted.
level_sensor  in  LEVEL_W  current water level, synchronous to clock.
valve  out  N_VALVES  registered valve drive.
busy  out  1  high in FILL or SETTLE.
done  out  1  high in DONE.
fault  out  1  high in FAULT.

Behaviour:
- Reset: state IDLE; valve=0, busy=0, done=0, fault=0; counters, captured target and captured mask all 0. Reset acts immediately, including mid-operation; valves close without waiting for a clock edge.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- IDLE:
  - start=1 and abort=0 at an edge → capture target and mask, clear the timeout counter.
  - Captured mask==0 → FAULT.
  - Otherwise, level_sensor >= target → SETTLE (no valve opens).
  - Otherwise → FILL.
- FILL:
  - valve = captured mask; the timeout counter increments every cycle in FILL.
  - level_sensor >= target → SETTLE; valve=0 from that edge; settle counter cleared.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with the level still below target → FAULT; valve=0 from that edge.
  - If the level and timeout conditions occur in the same cycle, the level condition wins (→ SETTLE).
- SETTLE:
  - valve=0; the settle counter increments each cycle.
  - level_sensor < target-HYST → FILL; the timeout counter is not cleared, so it is cumulative.
  - Subtraction saturates at 0: if target <= HYST the refill condition can never trigger.
  - Settle counter reaches SETTLE_CYCLES-1 → DONE.
- DONE: done=1, valve=0; held until start=0 is sampled, then → IDLE. This is a four-phase handshake; a held start never retriggers.
- FAULT: fault=1, valve=0; sticky. fault_clr=1 with start=0 → IDLE. fault_clr is ignored while start=1.
- abort=1 at any edge, in any state except FAULT → IDLE; valve=0 on that edge; counters cleared. FAULT ignores abort.
- Priority in every state: reset > abort > fault_clr > normal transitions.
- Captured target and mask are held constant for the whole operation; input changes after capture are ignored.

Test Plan:
- Basic fill: mask=2'b01, target=100, start held; sensor ramps 0→100 over 20 cycles → valve=01 the cycle after start is sampled; valve=00 on the edge where the sensor reads 100; done=1 exactly 16 cycles later; done falls one edge after start=0.
- Hysteresis refill: in SETTLE the sensor drops to 95 with target=100, HYST=4 → return to FILL, valve=01 again. Second case: sensor drops to 96 → stay in SETTLE, no refill.
- Timeout: TIMEOUT_CYCLES=50 (override), sensor stuck at 10, target=100 → fault=1 and valve=0 after 50 FILL cycles. fault_clr with start=1 → stays in FAULT; start=0 then fault_clr → IDLE.
- Abort and reset mid-fill: abort pulse in FILL → valve=00 and state IDLE on that edge. Separately, asserting reset between clock edges → valve=00 immediately, without waiting for an edge.
- Edge cases:
  - mask=00 with start → FAULT.
  - sensor already at or above target at start → SETTLE, then DONE; valve never asserted.
  - both valves, mask=11 → valve=11 during FILL.
- Simultaneous events: sensor reaches target on the same edge the timeout expires → SETTLE, not FAULT.
